uart_cmd_responder: RTL and testbench



---
 rtl/uart_cmd_responder.sv | 181 ++++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder.sv
// Serial command responder: turns uart byte frames into single 8-bit bus reads/writes
// and returns one response byte per frame through the uart transmitter.
module uart_cmd_responder #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned TIMEOUT  = 1000000,
  parameter logic [7:0]  ACK_BYTE = 8'hAA,
  parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [7:0]        uart_in_data,
  input  logic              uart_rx_empty,
  input  logic              uart_rx_ov,
  output logic              uart_rd,
  output logic [7:0]        uart_out_data,
  output logic              uart_wr,
  input  logic              uart_tx_empty,
  output logic              bus_cyc,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_adr,
  output logic [7:0]        bus_dat_w,
  input  logic [7:0]        bus_dat_r,
  input  logic              bus_ack,
  output logic              busy,
  output logic              frame_err
);

  localparam int unsigned CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [7:0]  CMD_WR = 8'h01;
  localparam logic [7:0]  CMD_RD = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_BUS, S_RESP, S_RESP_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_wr_q, is_wr_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [7:0]        wdat_q, wdat_d;
  logic [7:0]        resp_q, resp_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [7:0]        out_q, out_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              ferr_q, ferr_d;

  logic in_frame;
  logic take;
  logic tmo;

  // A byte may be taken only when no take happened last cycle; an overrun inside a frame blocks it.
  always_comb begin
    in_frame = (state_q == S_ADDR_HI) || (state_q == S_ADDR_LO) || (state_q == S_DATA);
    take     = ((state_q == S_IDLE) || (in_frame && !uart_rx_ov)) && !uart_rx_empty && !rd_q;
    tmo      = (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    is_wr_d   = is_wr_q;
    addr_hi_d = addr_hi_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    resp_d    = resp_q;
    out_d     = out_q;
    wr_d      = 1'b0;
    ferr_d    = 1'b0;
    rd_d      = take;

    case (state_q)
      S_IDLE: begin
        if (take) begin
          if ((uart_in_data == CMD_WR) || (uart_in_data == CMD_RD)) begin
            is_wr_d = (uart_in_data == CMD_WR);
            state_d = S_ADDR_HI;
          end else begin
            resp_d  = ERR_BYTE;
            state_d = S_RESP;
          end
        end
      end
      S_ADDR_HI, S_ADDR_LO, S_DATA: begin
        if (uart_rx_ov) begin
          ferr_d  = 1'b1;
          state_d = S_IDLE;
        end else if (take) begin
          if (state_q == S_ADDR_HI) begin
            addr_hi_d = uart_in_data;
            state_d   = S_ADDR_LO;
          end else if (state_q == S_ADDR_LO) begin
            adr_d   = ADDR_W'({addr_hi_q, uart_in_data});
            state_d = is_wr_q ? S_DATA : S_BUS;
          end else begin
            wdat_d  = uart_in_data;
            state_d = S_BUS;
          end
        end else if (tmo) begin
          ferr_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_BUS: begin
        if (bus_ack) begin
          resp_d  = is_wr_q ? ACK_BYTE : bus_dat_r;
          state_d = S_RESP;
        end else if (tmo) begin
          resp_d  = ERR_BYTE;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (uart_tx_empty) begin
          out_d   = resp_q;
          wr_d    = 1'b1;
          state_d = S_RESP_WAIT;
        end
      end
      S_RESP_WAIT: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    if (take || (state_d != state_q)) begin
      cnt_d = '0;
    end

    cyc_d  = (state_d == S_BUS);
    we_d   = cyc_d && is_wr_q;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_wr_q   <= 1'b0;
      addr_hi_q <= '0;
      adr_q     <= '0;
      wdat_q    <= '0;
      resp_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      out_q     <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_wr_q   <= is_wr_d;
      addr_hi_q <= addr_hi_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      resp_q    <= resp_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      out_q     <= out_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      ferr_q    <= ferr_d;
    end
  end

  assign uart_rd       = rd_q;
  assign uart_wr       = wr_q;
  assign uart_out_data = out_q;
  assign bus_cyc       = cyc_q;
  assign bus_we        = we_q;
  assign bus_adr       = adr_q;
  assign bus_dat_w     = wdat_q;
  assign busy          = busy_q;
  assign frame_err     = ferr_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: uart rx/tx and bus slave models, frame-level reference model.
module tb_uart_cmd_responder;

  localparam int unsigned TO   = 50;
  localparam logic [7:0]  ACKB = 8'hAA;
  localparam logic [7:0]  ERRB = 8'hEE;

  logic        clk, sys_rst;
  logic [7:0]  uart_in_data;
  logic        uart_rx_empty, uart_rx_ov, uart_rd;
  logic [7:0]  uart_out_data;
  logic        uart_wr, uart_tx_empty;
  logic        bus_cyc, bus_we;
  logic [15:0] bus_adr;
  logic [7:0]  bus_dat_w, bus_dat_r;
  logic        bus_ack, busy, frame_err;

  uart_cmd_responder #(.ADDR_W(16), .TIMEOUT(TO), .ACK_BYTE(ACKB), .ERR_BYTE(ERRB)) dut (
    .sys_clk(clk), .sys_rst(sys_rst),
    .uart_in_data(uart_in_data), .uart_rx_empty(uart_rx_empty), .uart_rx_ov(uart_rx_ov),
    .uart_rd(uart_rd), .uart_out_data(uart_out_data), .uart_wr(uart_wr),
    .uart_tx_empty(uart_tx_empty),
    .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_adr(bus_adr), .bus_dat_w(bus_dat_w),
    .bus_dat_r(bus_dat_r), .bus_ack(bus_ack), .busy(busy), .frame_err(frame_err)
  );

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [7:0]  dat;
    int          len;
  } bus_exp_t;

  typedef struct {
    logic [7:0] b;
    int         gap;
    logic       ov;
  } rx_ent_t;

  bus_exp_t   exp_bus[$];
  logic [7:0] exp_tx[$];
  int         exp_ferr[$];
  rx_ent_t    rxq[$];
  logic [7:0] ref_mem[int];
  logic [7:0] slv_mem[int];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rd_cnt = 0;
  int fed_cnt = 0;
  int ack_delay = 1;

  function automatic logic [7:0] init_mem(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // uart receiver model: holding register empties one cycle after the rd pulse
  initial begin
    logic    clr_pend;
    int      gcnt;
    rx_ent_t e;
    clr_pend = 1'b0;
    gcnt = 0;
    uart_rx_empty = 1'b1;
    uart_rx_ov = 1'b0;
    uart_in_data = 8'h00;
    forever begin
      @(negedge clk);
      uart_rx_ov = 1'b0;
      if (clr_pend) begin
        uart_rx_empty = 1'b1;
        clr_pend = 1'b0;
      end
      if (uart_rd) clr_pend = 1'b1;
      if (uart_rx_empty && !clr_pend && rxq.size() > 0) begin
        if (gcnt < rxq[0].gap) gcnt++;
        else begin
          e = rxq.pop_front();
          uart_in_data  = e.b;
          uart_rx_empty = 1'b0;
          uart_rx_ov    = e.ov;
          gcnt = 0;
          fed_cnt++;
        end
      end
    end
  end

  // uart transmitter model: busy for a few cycles after each load
  initial begin
    int tx_cnt;
    tx_cnt = 0;
    uart_tx_empty = 1'b1;
    forever begin
      @(negedge clk);
      if (sys_rst) begin
        tx_cnt = 0;
        uart_tx_empty = 1'b1;
      end else if (uart_wr) tx_cnt = 12;
      else if (tx_cnt > 0) begin
        if (tx_cnt == 12) uart_tx_empty = 1'b0;
        tx_cnt--;
        if (tx_cnt == 0) uart_tx_empty = 1'b1;
      end
    end
  end

  // bus slave: acks after ack_delay cycles of bus_cyc; ack_delay 0 means never
  initial begin
    int bcnt;
    bcnt = 0;
    bus_ack = 1'b0;
    bus_dat_r = 8'h00;
    forever begin
      @(negedge clk);
      if (sys_rst) begin
        bus_ack = 1'b0;
        bcnt = 0;
      end else if (bus_ack) begin
        bus_ack = 1'b0;
        bus_dat_r = 8'($urandom);
      end else if (!bus_cyc) bcnt = 0;
      else begin
        bcnt++;
        if (ack_delay > 0 && bcnt == ack_delay) begin
          bus_ack = 1'b1;
          if (bus_we) slv_mem[int'(bus_adr)] = bus_dat_w;
          else bus_dat_r = slv_mem.exists(int'(bus_adr)) ? slv_mem[int'(bus_adr)] : init_mem(bus_adr);
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a bus cycle, tx byte or frame error
  initial begin
    logic     prev_rd, prev_cyc;
    int       blen, cur_len, last_rd, g;
    bus_exp_t eb;
    logic [7:0] t;
    prev_rd = 1'b0; prev_cyc = 1'b0; blen = 0; cur_len = -1; last_rd = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (sys_rst) begin
        prev_rd = 1'b0;
        prev_cyc = 1'b0;
      end else begin
        if (uart_rd) begin
          chk("rd_not_back_to_back", int'(prev_rd), 0);
          rd_cnt++;
          last_rd = cyc;
        end
        prev_rd = uart_rd;
        if (bus_cyc && !prev_cyc) begin
          blen = 1;
          if (exp_bus.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_bus_cycle: got adr=%0h we=%0b, expected none", bus_adr, bus_we);
            cur_len = -1;
          end else begin
            eb = exp_bus.pop_front();
            chk("bus_we", int'(bus_we), int'(eb.we));
            chk("bus_adr", int'(bus_adr), int'(eb.adr));
            if (eb.we) chk("bus_dat_w", int'(bus_dat_w), int'(eb.dat));
            cur_len = eb.len;
          end
        end else if (bus_cyc) blen++;
        else if (prev_cyc && cur_len >= 0) chk("bus_cyc_len", blen, cur_len);
        prev_cyc = bus_cyc;
        if (uart_wr) begin
          if (exp_tx.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_tx: got=%0h expected none", uart_out_data);
          end else begin
            t = exp_tx.pop_front();
            chk("tx_byte", int'(uart_out_data), int'(t));
          end
        end
        if (frame_err) begin
          if (exp_ferr.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_frame_err: got pulse at cycle %0d, expected none", cyc);
          end else begin
            g = exp_ferr.pop_front();
            if (g >= 0) chk("frame_err_delay", cyc - last_rd, g);
          end
        end
      end
    end
  end

  task automatic push_rx(input logic [7:0] b, input logic ov);
    rx_ent_t e;
    e.b = b;
    e.gap = $urandom_range(0, 4);
    e.ov = ov;
    rxq.push_back(e);
  endtask

  // Reference model: expected bus cycle and response for one frame, then queue its bytes
  task automatic run_frame(input logic [7:0] cmd, input logic [15:0] adr, input logic [7:0] dat,
                           input int ackd, input logic ov_first);
    bus_exp_t eb;
    ack_delay = ackd;
    if (cmd != 8'h01 && cmd != 8'h02) exp_tx.push_back(ERRB);
    else begin
      eb.we = (cmd == 8'h01);
      eb.adr = adr;
      eb.dat = dat;
      eb.len = (ackd > 0) ? ackd : int'(TO);
      exp_bus.push_back(eb);
      if (ackd == 0) exp_tx.push_back(ERRB);
      else if (eb.we) begin
        exp_tx.push_back(ACKB);
        ref_mem[int'(adr)] = dat;
      end else exp_tx.push_back(ref_mem.exists(int'(adr)) ? ref_mem[int'(adr)] : init_mem(adr));
    end
    push_rx(cmd, ov_first);
    if (cmd == 8'h01 || cmd == 8'h02) begin
      push_rx(adr[15:8], 1'b0);
      push_rx(adr[7:0], 1'b0);
      if (cmd == 8'h01) push_rx(dat, 1'b0);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 3000 && !(rxq.size() == 0 && exp_tx.size() == 0 && exp_bus.size() == 0 &&
                         exp_ferr.size() == 0 && !busy && !bus_cyc)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL %s_wait: frame still pending after %0d cycles, expected completion", name, n);
    end
    repeat (3) @(negedge clk);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_rd_count"}, rd_cnt, fed_cnt);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [7:0]  cmd, dat;
    logic [15:0] adr;
    int          n, r;
    bus_exp_t    eb;
    sys_rst = 1'b0;
    #2 sys_rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_bus_cyc", int'(bus_cyc), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_uart_rd", int'(uart_rd), 0);
    chk("rst_uart_wr", int'(uart_wr), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_bus_adr", int'(bus_adr), 0);
    sys_rst = 1'b0;
    repeat (3) @(negedge clk);

    run_frame(8'h01, 16'h1234, 8'h5A, 3, 1'b0);
    wait_idle("write");

    slv_mem[16'h0010] = 8'hC3;
    ref_mem[16'h0010] = 8'hC3;
    run_frame(8'h02, 16'h0010, 8'h00, 2, 1'b0);
    wait_idle("read");

    run_frame(8'h7F, 16'h0000, 8'h00, 1, 1'b0);
    wait_idle("bad_cmd");
    run_frame(8'h02, 16'h0001, 8'h00, 1, 1'b0);
    wait_idle("after_bad");

    exp_ferr.push_back(int'(TO));
    push_rx(8'h01, 1'b0);
    push_rx(8'h12, 1'b0);
    wait_idle("interbyte_tmo");
    run_frame(8'h01, 16'h0022, 8'h66, 2, 1'b0);
    wait_idle("after_tmo");

    run_frame(8'h02, 16'h0022, 8'h00, 0, 1'b0);
    wait_idle("bus_tmo");

    // overrun in ADDR_HI with a byte pending: that byte restarts as a new command
    exp_ferr.push_back(-1);
    push_rx(8'h01, 1'b0);
    run_frame(8'h02, 16'h0022, 8'h00, 2, 1'b1);
    wait_idle("overrun");

    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      adr = ($urandom_range(0, 1) == 1) ? 16'($urandom) : {12'h3A0, 4'($urandom_range(0, 3))};
      dat = 8'($urandom);
      if (r < 4) cmd = 8'h01;
      else if (r < 8) cmd = 8'h02;
      else begin
        cmd = 8'($urandom);
        while (cmd == 8'h01 || cmd == 8'h02) cmd = 8'($urandom);
      end
      run_frame(cmd, adr, dat, $urandom_range(1, 5), 1'b0);
      wait_idle("random");
    end

    // reset while a write is stuck in the bus cycle
    eb.we = 1'b1; eb.adr = 16'hBEEF; eb.dat = 8'h77; eb.len = -1;
    exp_bus.push_back(eb);
    ack_delay = 0;
    push_rx(8'h01, 1'b0);
    push_rx(8'hBE, 1'b0);
    push_rx(8'hEF, 1'b0);
    push_rx(8'h77, 1'b0);
    n = 0;
    while (!bus_cyc && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_bus_reached", int'(bus_cyc), 1);
    repeat (4) @(negedge clk);
    #2 sys_rst = 1'b1;
    #1;
    chk("midrst_bus_cyc", int'(bus_cyc), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_uart_rd", int'(uart_rd), 0);
    chk("midrst_uart_wr", int'(uart_wr), 0);
    @(negedge clk);
    @(negedge clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge clk);
    run_frame(8'h01, 16'hBEEF, 8'h77, 2, 1'b0);
    wait_idle("post_rst_write");
    run_frame(8'h02, 16'hBEEF, 8'h00, 3, 1'b0);
    wait_idle("post_rst_read");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
